// File: rtl/inst_fetch_pkg.sv
// Shared types and helpers for the instruction fetch queue.
package inst_fetch_pkg;

  localparam int INST_W = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  // Number of byte-address bits covered by one fetch line of fw instructions.
  function automatic int line_lb(input int fw);
    return $clog2(fw) + 2;
  endfunction

endpackage

// File: rtl/inst_fetch_align.sv
// Turns one aligned fetch line into a compacted list of the wanted slots
// (those at or above fetch_pc), oldest first, plus how many there are.
module inst_fetch_align
  import inst_fetch_pkg::*;
#(
  parameter int FETCH_WIDTH = 2
) (
  input  logic [31:0]                    fetch_pc,
  input  logic [FETCH_WIDTH*INST_W-1:0]  fetch_rdata,
  output fq_entry_t [FETCH_WIDTH-1:0]    slots,
  output logic [$clog2(FETCH_WIDTH):0]   n_in
);

  localparam int LB = line_lb(FETCH_WIDTH);
  localparam int SW = LB - 2;
  localparam int NW = SW + 1;

  logic [SW-1:0] start;
  logic [31:0]   line_base;
  logic          unused_pc_lsb;

  assign start         = fetch_pc[LB-1:2];
  assign line_base     = {fetch_pc[31:LB], {LB{1'b0}}};
  assign n_in          = NW'(FETCH_WIDTH) - NW'(start);
  assign unused_pc_lsb = ^fetch_pc[1:0];

  // Slot 0 sits in the MSBs of the line; output i takes slot start+i.
  always_comb begin
    slots = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (k == int'(start) + i) begin
          slots[i].inst = fetch_rdata[(FETCH_WIDTH-k)*INST_W-1 -: INST_W];
          slots[i].pc   = line_base + 32'(4 * k);
        end
      end
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Circular instruction fetch queue feeding dual-issue decode.
// Optional same-cycle bypass on an empty queue: define INST_FETCH_QUEUE_BYPASS_EN.
module inst_fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int DEPTH       = 16
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           flush,
  input  logic                           fetch_valid,
  input  logic [31:0]                    fetch_pc,
  input  logic [FETCH_WIDTH*INST_W-1:0]  fetch_rdata,
  output logic                           fetch_ready,
  output logic                           deq_valid1,
  output logic                           deq_valid2,
  output logic [31:0]                    deq_inst1,
  output logic [31:0]                    deq_inst2,
  output logic [31:0]                    deq_pc1,
  output logic [31:0]                    deq_pc2,
  input  logic [1:0]                     deq_num,
  output logic                           empty,
  output logic                           full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = $clog2(FETCH_WIDTH) + 1;

  fq_entry_t                  mem [DEPTH];
  logic [PW-1:0]              head;
  logic [PW-1:0]              tail;
  logic [CW-1:0]              count;

  fq_entry_t [FETCH_WIDTH-1:0] slots;
  logic [NW-1:0]              n_in;

  logic                       push;
  logic                       byp;
  logic [CW-1:0]              free_cnt;
  logic [CW-1:0]              n_push;
  logic [CW-1:0]              n_pop;
  logic [CW-1:0]              skip;
  logic [CW-1:0]              n_wr;
  logic [CW-1:0]              n_adv;
  logic [PW-1:0]              head_p1;

  fq_entry_t                  e1;
  fq_entry_t                  e2;
  logic                       v1;
  logic                       v2;
  logic [1:0]                 n_avail;

  inst_fetch_align #(
    .FETCH_WIDTH (FETCH_WIDTH)
  ) u_align (
    .fetch_pc    (fetch_pc),
    .fetch_rdata (fetch_rdata),
    .slots       (slots),
    .n_in        (n_in)
  );

  // Readiness looks only at the registered count so PC generation never
  // depends combinationally on decode's pop decision.
  assign free_cnt    = CW'(DEPTH) - count;
  assign fetch_ready = free_cnt >= CW'(FETCH_WIDTH);
  assign push        = fetch_valid & fetch_ready & ~flush;
  assign n_push      = push ? CW'(n_in) : '0;
  assign n_pop       = flush ? '0 : CW'(deq_num);

`ifdef INST_FETCH_QUEUE_BYPASS_EN
  assign byp = push & (count == '0);
`else
  assign byp = 1'b0;
`endif

  // Bypassed entries consumed this cycle never touch storage or move head.
  assign skip    = byp ? n_pop : '0;
  assign n_wr    = n_push - skip;
  assign n_adv   = n_pop - skip;
  assign head_p1 = head + PW'(1);

  always_comb begin
    e1 = mem[head];
    e2 = mem[head_p1];
    v1 = count >= CW'(1);
    v2 = count >= CW'(2);
    if (byp) begin
      e1 = slots[0];
      e2 = slots[1];
      v1 = 1'b1;
      v2 = n_in >= NW'(2);
    end
  end

  assign deq_valid1 = v1;
  assign deq_valid2 = v2;
  assign deq_inst1  = v1 ? e1.inst : '0;
  assign deq_pc1    = v1 ? e1.pc   : '0;
  assign deq_inst2  = v2 ? e2.inst : '0;
  assign deq_pc2    = v2 ? e2.pc   : '0;
  assign empty      = count == '0;
  assign full       = count == CW'(DEPTH);
  assign n_avail    = {1'b0, v1} + {1'b0, v2};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(n_adv);
      tail  <= tail + PW'(n_wr);
      count <= count + n_push - n_pop;
    end
  end

  // Storage is data only: no reset, contents after flush are don't-care.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (push && (i >= int'(skip)) && (i < int'(n_in))) begin
        mem[tail + PW'(i) - PW'(skip)] <= slots[i];
      end
    end
  end

  a_deq_num_legal: assert property (@(posedge clk) disable iff (!resetn)
    !flush |-> (deq_num <= n_avail));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (FETCH_WIDTH=2, DEPTH=16) with a scoreboard.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [63:0] fetch_rdata;
  logic        fetch_ready;
  logic        deq_valid1;
  logic        deq_valid2;
  logic [31:0] deq_inst1;
  logic [31:0] deq_inst2;
  logic [31:0] deq_pc1;
  logic [31:0] deq_pc2;
  logic [1:0]  deq_num;
  logic        empty;
  logic        full;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] sbq[$];

  int          m_sz;
  logic        m_byp;
  logic        m_v1;
  logic        m_v2;
  logic [63:0] m_e1;
  logic [63:0] m_e2;

  always #5 clk = ~clk;

  inst_fetch_queue #(
    .FETCH_WIDTH (2),
    .DEPTH       (16)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_rdata (fetch_rdata),
    .fetch_ready (fetch_ready),
    .deq_valid1  (deq_valid1),
    .deq_valid2  (deq_valid2),
    .deq_inst1   (deq_inst1),
    .deq_inst2   (deq_inst2),
    .deq_pc1     (deq_pc1),
    .deq_pc2     (deq_pc2),
    .deq_num     (deq_num),
    .empty       (empty),
    .full        (full)
  );

  function automatic logic [63:0] slot_ent(input logic [31:0] pc, input logic [63:0] rd, input int k);
    logic [31:0] base;
    base = {pc[31:3], 3'b000};
    return {base + 32'(4 * k), (k == 0) ? rd[63:32] : rd[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected queue contents: appended when a line is accepted, consumed by deq_num.
  always @(posedge clk) begin
    if (resetn) begin
      if (flush) begin
        sbq.delete();
      end else begin
        if (fetch_valid && ((16 - sbq.size()) >= 2)) begin
          for (int k = int'(fetch_pc[2]); k < 2; k++) sbq.push_back(slot_ent(fetch_pc, fetch_rdata, k));
        end
        for (int k = 0; k < int'(deq_num); k++) begin
          if (sbq.size() > 0) void'(sbq.pop_front());
        end
      end
    end
  end

  always @(negedge resetn) sbq.delete();

  // Monitor: compare presented outputs against the head of the scoreboard.
  always @(negedge clk) begin
    m_sz  = sbq.size();
    m_byp = 1'b0;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
    m_byp = resetn && (m_sz == 0) && fetch_valid && !flush;
`endif
    if (m_byp) begin
      m_v1 = 1'b1;
      m_e1 = slot_ent(fetch_pc, fetch_rdata, int'(fetch_pc[2]));
      m_v2 = !fetch_pc[2];
      m_e2 = m_v2 ? slot_ent(fetch_pc, fetch_rdata, 1) : 64'h0;
    end else begin
      m_v1 = m_sz >= 1;
      m_e1 = m_v1 ? sbq[0] : 64'h0;
      m_v2 = m_sz >= 2;
      m_e2 = m_v2 ? sbq[1] : 64'h0;
    end
    chk("mon_valid1", 32'(deq_valid1), 32'(m_v1));
    chk("mon_valid2", 32'(deq_valid2), 32'(m_v2));
    chk("mon_pc1", deq_pc1, m_e1[63:32]);
    chk("mon_inst1", deq_inst1, m_e1[31:0]);
    chk("mon_pc2", deq_pc2, m_e2[63:32]);
    chk("mon_inst2", deq_inst2, m_e2[31:0]);
    chk("mon_empty", 32'(empty), 32'(m_sz == 0));
    chk("mon_full", 32'(full), 32'(m_sz == 16));
    chk("mon_ready", 32'(fetch_ready), 32'((16 - m_sz) >= 2));
  end

  task automatic cycle(input logic fv, input logic [31:0] pc, input logic [63:0] rd,
                       input logic [1:0] dn, input logic fl);
    fetch_valid = fv;
    fetch_pc    = pc;
    fetch_rdata = rd;
    deq_num     = dn;
    flush       = fl;
    @(posedge clk);
    #1;
    fetch_valid = 1'b0;
    deq_num     = 2'd0;
    flush       = 1'b0;
  endtask

  function automatic logic [1:0] dn_safe(input int want);
    int s;
    s = sbq.size();
    return 2'((want < s) ? want : s);
  endfunction

  task automatic drain();
    for (int n = 0; n < 20; n++) begin
      if (sbq.size() > 0) cycle(1'b0, 32'h0, 64'h0, dn_safe(2), 1'b0);
    end
    chk("drain_empty", 32'(empty), 32'd1);
  endtask

  initial begin
    resetn      = 1'b0;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    fetch_pc    = 32'h0;
    fetch_rdata = 64'h0;
    deq_num     = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(fetch_ready), 32'd1);
    chk("rst_valid1", 32'(deq_valid1), 32'd0);
    chk("rst_valid2", 32'(deq_valid2), 32'd0);
    chk("rst_inst1", deq_inst1, 32'h0);
    chk("rst_pc1", deq_pc1, 32'h0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    resetn = 1'b1;

    // Aligned line: both slots queued.
    cycle(1'b1, 32'h1000, {32'hAAAA0001, 32'hBBBB0002}, 2'd0, 1'b0);
    chk("t1_valid1", 32'(deq_valid1), 32'd1);
    chk("t1_inst1", deq_inst1, 32'hAAAA0001);
    chk("t1_pc1", deq_pc1, 32'h1000);
    chk("t1_valid2", 32'(deq_valid2), 32'd1);
    chk("t1_inst2", deq_inst2, 32'hBBBB0002);
    chk("t1_pc2", deq_pc2, 32'h1004);
    cycle(1'b0, 32'h0, 64'h0, 2'd2, 1'b0);
    chk("t1_empty", 32'(empty), 32'd1);

    // Unaligned PC: slot 0 dropped.
    cycle(1'b1, 32'h1004, {32'hAAAA0001, 32'hBBBB0002}, 2'd0, 1'b0);
    chk("t2_valid1", 32'(deq_valid1), 32'd1);
    chk("t2_valid2", 32'(deq_valid2), 32'd0);
    chk("t2_inst1", deq_inst1, 32'hBBBB0002);
    chk("t2_pc1", deq_pc1, 32'h1004);
    chk("t2_inst2", deq_inst2, 32'h0);

    // Fill to 15: one free slot is not enough for a line.
    for (int i = 0; i < 7; i++)
      cycle(1'b1, 32'h3000 + 32'(8 * i), {32'h3000_0000 + 32'(i), 32'h3100_0000 + 32'(i)}, 2'd0, 1'b0);
    chk("t3_ready_low", 32'(fetch_ready), 32'd0);
    chk("t3_not_full", 32'(full), 32'd0);
    cycle(1'b1, 32'h3100, 64'hDEAD_BEEF_DEAD_BEEF, 2'd1, 1'b0);
    chk("t3_ready_back", 32'(fetch_ready), 32'd1);
    chk("t3_head_pc", deq_pc1, 32'h3000);
    cycle(1'b1, 32'h3200, {32'h3200_0000, 32'h3200_0001}, 2'd0, 1'b0);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_full_ready", 32'(fetch_ready), 32'd0);
    drain();

    // Flush beats a same-cycle fetch and pop.
    cycle(1'b1, 32'h4000, {32'h4000_0000, 32'h4000_0001}, 2'd0, 1'b0);
    cycle(1'b1, 32'h4008, {32'h4008_0000, 32'h4008_0001}, 2'd0, 1'b0);
    cycle(1'b1, 32'h4010, {32'h4010_0000, 32'h4010_0001}, 2'd2, 1'b1);
    chk("t4_empty", 32'(empty), 32'd1);
    chk("t4_valid1", 32'(deq_valid1), 32'd0);
    chk("t4_ready", 32'(fetch_ready), 32'd1);
    cycle(1'b0, 32'h0, 64'h0, 2'd0, 1'b0);
    chk("t4_still_empty", 32'(empty), 32'd1);

    // Pointer wrap under interleaved push and pop.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  dn;
      logic [31:0] pc;
      dn = (i % 2 == 1) ? ((i % 4 == 1) ? 2'd1 : 2'd2) : 2'd0;
      pc = 32'h5000 + 32'(8 * i) + ((i % 8 == 6) ? 32'h4 : 32'h0);
      cycle(i % 2 == 0, pc, {32'hD000_0000 + 32'(i), 32'hE000_0000 + 32'(i)}, dn_safe(int'(dn)), 1'b0);
    end
    drain();

    // Asynchronous reset mid-stream with six entries queued.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h6000 + 32'(8 * i), {32'h6000_0000 + 32'(i), 32'h6100_0000 + 32'(i)}, 2'd0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_valid1", 32'(deq_valid1), 32'd0);
    chk("t6_valid2", 32'(deq_valid2), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_ready", 32'(fetch_ready), 32'd1);
    chk("t6_pc1", deq_pc1, 32'h0);
    chk("t6_inst1", deq_inst1, 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

`ifdef INST_FETCH_QUEUE_BYPASS_EN
    fetch_valid = 1'b1;
    fetch_pc    = 32'h2000;
    fetch_rdata = {32'h2000_AAAA, 32'h2000_BBBB};
    #1;
    chk("byp_valid1", 32'(deq_valid1), 32'd1);
    chk("byp_pc1", deq_pc1, 32'h2000);
    chk("byp_inst1", deq_inst1, 32'h2000_AAAA);
    @(posedge clk);
    #1;
    fetch_valid = 1'b0;
    drain();
`endif

    cycle(1'b0, 32'h0, 64'h0, 2'd0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
